// File: rtl/dircc_debug_jtag_host.sv
// rtl/dircc_debug_jtag_host.sv - virtual-JTAG debug host: loads IR, shifts one data register, returns capture
module dircc_debug_jtag_host #(
    parameter int TCK_HALF = 2,
    parameter int SR_WIDTH = 38
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic [1:0]          rsp_ir_out,
    output logic                busy,
    output logic                vji_tck,
    output logic                vji_tdi,
    input  logic                vji_tdo,
    output logic [1:0]          vji_ir_in,
    input  logic [1:0]          vji_ir_out,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] UIR  = 3'd1;
    localparam logic [2:0] CDR  = 3'd2;
    localparam logic [2:0] SDR  = 3'd3;
    localparam logic [2:0] UDR  = 3'd4;
    localparam logic [2:0] RTI  = 3'd5;
    localparam logic [2:0] RSP  = 3'd6;

    localparam logic [3:0] HALF_LAST = 4'(TCK_HALF - 1);
    localparam logic [5:0] BIT_LAST  = 6'(SR_WIDTH - 1);

    logic [2:0]          state_q, state_d;
    logic [3:0]          half_q, half_d;
    logic                tck_q, tck_d;
    logic [5:0]          bit_q, bit_d;
    logic [SR_WIDTH-1:0] sr_q, sr_d;
    logic [1:0]          ir_in_q, ir_in_d;
    logic [1:0]          ir_out_q, ir_out_d;

    logic tick, tck_rise, tck_fall;

    // A tck period ends on its falling toggle; that is also where states advance.
    assign tick     = (half_q == HALF_LAST);
    assign tck_rise = tick && !tck_q;
    assign tck_fall = tick && tck_q;

    always_comb begin
        state_d  = state_q;
        half_d   = half_q;
        tck_d    = tck_q;
        bit_d    = bit_q;
        sr_d     = sr_q;
        ir_in_d  = ir_in_q;
        ir_out_d = ir_out_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = UIR;
                    ir_in_d = cmd_ir;
                    sr_d    = cmd_data;
                    half_d  = 4'd0;
                    tck_d   = 1'b0;
                    bit_d   = 6'd0;
                end
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: begin
                if (tick) begin
                    half_d = 4'd0;
                    tck_d  = ~tck_q;
                end else begin
                    half_d = half_q + 4'd1;
                end
                if (tck_rise && state_q == UIR) ir_out_d = vji_ir_out;
                if (tck_rise && state_q == SDR) sr_d = {vji_tdo, sr_q[SR_WIDTH-1:1]};
                if (tck_fall) begin
                    case (state_q)
                        UIR: state_d = CDR;
                        CDR: state_d = SDR;
                        SDR: begin
                            if (bit_q == BIT_LAST) begin
                                bit_d   = 6'd0;
                                state_d = UDR;
                            end else begin
                                bit_d = bit_q + 6'd1;
                            end
                        end
                        UDR:     state_d = RTI;
                        RTI:     state_d = RSP;
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            half_q   <= 4'd0;
            tck_q    <= 1'b0;
            bit_q    <= 6'd0;
            sr_q     <= '0;
            ir_in_q  <= 2'b00;
            ir_out_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            half_q   <= half_d;
            tck_q    <= tck_d;
            bit_q    <= bit_d;
            sr_q     <= sr_d;
            ir_in_q  <= ir_in_d;
            ir_out_q <= ir_out_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = (state_q == RSP);
    assign rsp_data   = sr_q;
    assign rsp_ir_out = ir_out_q;
    assign vji_tck    = tck_q;
    assign vji_tdi    = (state_q == SDR) ? sr_q[0] : 1'b0;
    assign vji_ir_in  = ir_in_q;
    assign vji_uir    = (state_q == UIR);
    assign vji_cdr    = (state_q == CDR);
    assign vji_sdr    = (state_q == SDR);
    assign vji_udr    = (state_q == UDR);
    assign vji_rti    = (state_q == RTI);

endmodule

// File: tb/tb_dircc_debug_jtag_host.sv
// tb/tb_dircc_debug_jtag_host.sv - directed bench for dircc_debug_jtag_host
module tb_dircc_debug_jtag_host;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_valid1 = 1'b0;
    logic [1:0]  cmd_ir = 2'b00;
    logic [37:0] cmd_data = '0;
    logic        rsp_ready = 1'b0;
    logic [1:0]  vji_ir_out = 2'b00;
    logic        tdo_mode = 1'b0;

    logic        cmd_ready, rsp_valid, busy, tck0, tdi0, tdo0;
    logic [37:0] rsp_data;
    logic [1:0]  rsp_ir_out, ir_in0;
    logic        uir0, cdr0, sdr0, udr0, rti0;

    logic        cmd_ready1, rsp_valid1, busy1, tck1, tdi1;
    logic [37:0] rsp_data1;
    logic [1:0]  rsp_ir_out1, ir_in1;
    logic        uir1, cdr1, sdr1, udr1, rti1;

    assign tdo0 = tdo_mode ? 1'b1 : tdi0;

    always #5 clk = ~clk;

    dircc_debug_jtag_host dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_ir_out(rsp_ir_out), .busy(busy), .vji_tck(tck0),
        .vji_tdi(tdi0), .vji_tdo(tdo0), .vji_ir_in(ir_in0), .vji_ir_out(vji_ir_out),
        .vji_uir(uir0), .vji_cdr(cdr0), .vji_sdr(sdr0), .vji_udr(udr0), .vji_rti(rti0)
    );

    dircc_debug_jtag_host #(.TCK_HALF(1), .SR_WIDTH(38)) dut1 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data1), .rsp_ir_out(rsp_ir_out1), .busy(busy1), .vji_tck(tck1),
        .vji_tdi(tdi1), .vji_tdo(tdi1), .vji_ir_in(ir_in1), .vji_ir_out(vji_ir_out),
        .vji_uir(uir1), .vji_cdr(cdr1), .vji_sdr(sdr1), .vji_udr(udr1), .vji_rti(rti1)
    );

    int   sdr_rises = 0;
    logic tck0_prev = 1'b0, tck1_prev = 1'b0;
    int   cyc1 = 0, last_rise1 = 0, per1 = 0;

    always @(negedge clk) begin
        tck0_prev <= tck0;
        tck1_prev <= tck1;
        cyc1      <= cyc1 + 1;
        if (tck0 && !tck0_prev && sdr0) sdr_rises <= sdr_rises + 1;
        if (tck1 && !tck1_prev) begin
            if (last_rise1 > 0) per1 <= cyc1 - last_rise1;
            last_rise1 <= cyc1;
        end
    end

    int passed = 0, total = 0;
    int lat0 = 0, lat1 = 0, base = 0, n = 0;
    logic flag;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk); #1;
            lat0++;
        end
    endtask

    task automatic start0(input logic [1:0] ir, input logic [37:0] d);
        cmd_ir = ir; cmd_data = d; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat0 = 1;
    endtask

    task automatic wait_rsp0();
        while (!rsp_valid && lat0 < 400) step(1);
    endtask

    task automatic release_rsp0();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tck_async", {63'd0, tck0}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_strobes", {57'd0, uir0, cdr0, sdr0, udr0, rti0, rsp_valid, tdi0}, 64'd0);
        chk("rst_data", {22'd0, rsp_ir_out, ir_in0, rsp_data}, 64'd0);

        // loopback, latency and held response
        vji_ir_out = 2'b11;
        start0(2'b01, 38'h2A_5A5A_5A5A);
        chk("uir_entry", {62'd0, uir0, tck0}, 64'd2);
        chk("ir_in_loaded", {62'd0, ir_in0}, 64'd1);
        wait_rsp0();
        chk("latency_169", 64'(lat0), 64'd169);
        chk("loop_data", {26'd0, rsp_data}, 64'h2A_5A5A_5A5A);
        chk("ir_out_11", {62'd0, rsp_ir_out}, 64'd3);
        flag = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (!rsp_valid || cmd_ready || rsp_data !== 38'h2A_5A5A_5A5A || tck0) flag = 1'b0;
        end
        chk("rsp_held_20", {63'd0, flag}, 64'd1);
        release_rsp0();
        chk("idle_after_rsp", {62'd0, cmd_ready, rsp_valid}, 64'd2);

        // constant-one tdo
        tdo_mode = 1'b1; vji_ir_out = 2'b10;
        base = sdr_rises;
        start0(2'b10, 38'h01_2345_6789);
        wait_rsp0();
        chk("ones_data", {26'd0, rsp_data}, 64'h3F_FFFF_FFFF);
        chk("ones_ir_out", {62'd0, rsp_ir_out}, 64'd2);
        chk("sdr_rises_38", 64'(sdr_rises - base), 64'd38);
        release_rsp0();
        tdo_mode = 1'b0;

        // command offered mid-SDR must be ignored
        start0(2'b01, 38'h15_0F0F_1234);
        while (!sdr0 && lat0 < 400) step(1);
        step(7);
        cmd_ir = 2'b10; cmd_data = 38'h3C_DEAD_BEEF; cmd_valid = 1'b1;
        chk("busy_not_ready", {62'd0, cmd_ready, busy}, 64'd1);
        step(1);
        cmd_valid = 1'b0;
        chk("ir_in_kept", {62'd0, ir_in0}, 64'd1);
        wait_rsp0();
        chk("ignore_latency", 64'(lat0), 64'd169);
        chk("ignore_data", {26'd0, rsp_data}, 64'h15_0F0F_1234);
        release_rsp0();

        // reset after the 10th SDR bit
        base = sdr_rises;
        start0(2'b11, 38'h0A_AAAA_5555);
        n = 0;
        while ((sdr_rises - base) < 10 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_bit10", {63'd0, sdr0}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midsdr_rst_strobes", {56'd0, uir0, cdr0, sdr0, udr0, rti0, rsp_valid, tdi0, tck0}, 64'd0);
        chk("midsdr_rst_state", {62'd0, busy, cmd_ready}, 64'd1);
        chk("midsdr_rst_data", {22'd0, rsp_ir_out, ir_in0, rsp_data}, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        flag = 1'b1;
        repeat (200) begin
            @(posedge clk); #1;
            if (rsp_valid || busy) flag = 1'b0;
        end
        chk("no_rsp_after_rst", {63'd0, flag}, 64'd1);
        vji_ir_out = 2'b01;
        start0(2'b10, 38'h23_8001_C003);
        wait_rsp0();
        chk("post_rst_latency", 64'(lat0), 64'd169);
        chk("post_rst_data", {26'd0, rsp_data}, 64'h23_8001_C003);
        chk("post_rst_ir", {60'd0, ir_in0, rsp_ir_out}, 64'h9);
        release_rsp0();

        // TCK_HALF=1 instance
        cmd_ir = 2'b01; cmd_data = 38'h1; cmd_valid1 = 1'b1;
        @(posedge clk); #1;
        cmd_valid1 = 1'b0;
        lat1 = 1;
        while (!rsp_valid1 && lat1 < 400) begin
            @(posedge clk); #1;
            lat1++;
        end
        chk("th1_latency_85", 64'(lat1), 64'd85);
        chk("th1_data", {26'd0, rsp_data1}, 64'd1);
        chk("th1_tck_period", 64'(per1), 64'd2);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("th1_idle", {62'd0, cmd_ready1, rsp_valid1}, 64'd2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
